// File: rtl/bsg_wormhole_router_adapter_deserializer.sv
// Wormhole link to wide packet deserializer: gathers a header flit plus len body flits
// into a single-packet buffer and presents {payload, len, cord} with valid/ready_and.
module bsg_wormhole_router_adapter_deserializer #(
  parameter int max_payload_width_p = 100,
  parameter int len_width_p         = 3,
  parameter int cord_width_p        = 5,
  parameter int flit_width_p        = 32
) (
  input  logic                                                     clk_i,
  input  logic                                                     reset_n_i,
  input  logic [flit_width_p-1:0]                                  link_data_i,
  input  logic                                                     link_v_i,
  output logic                                                     link_ready_and_o,
  output logic [cord_width_p+len_width_p+max_payload_width_p-1:0] packet_o,
  output logic                                                     packet_v_o,
  input  logic                                                     packet_ready_and_i
);

  localparam int pkt_w_lp     = cord_width_p + len_width_p + max_payload_width_p;
  localparam int max_flits_lp = (pkt_w_lp + flit_width_p - 1) / flit_width_p;
  localparam int cnt_w_lp     = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;
  localparam int last_max_lp  = max_flits_lp - 1;
  localparam int buf_w_lp     = max_flits_lp * flit_width_p;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
  logic [cnt_w_lp-1:0]    last_q, last_d;
  logic [buf_w_lp-1:0]    buf_q, buf_d;
  logic [len_width_p-1:0] hdr_len;
  int unsigned            hdr_len_int;

  assign hdr_len     = link_data_i[cord_width_p +: len_width_p];
  assign hdr_len_int = int'(hdr_len);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (link_v_i) begin
          buf_d                   = '0;
          buf_d[flit_width_p-1:0] = link_data_i;
          // Oversized len saturates the terminal count so cnt can never index past the buffer
          last_d = (hdr_len_int > last_max_lp) ? cnt_w_lp'(last_max_lp) : cnt_w_lp'(hdr_len_int);
          if (hdr_len_int == 0 || last_max_lp == 0) begin
            state_d = FULL;
          end else begin
            cnt_d   = cnt_w_lp'(1);
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (link_v_i) begin
          for (int unsigned i = 1; i < max_flits_lp; i++) begin
            if (cnt_q == cnt_w_lp'(i)) begin
              buf_d[i*flit_width_p +: flit_width_p] = link_data_i;
            end
          end
          if (cnt_q == last_q) begin
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + cnt_w_lp'(1);
          end
        end
      end
      FULL: begin
        if (packet_ready_and_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && state_q == IDLE && link_v_i) begin
      assert (hdr_len_int <= last_max_lp)
        else $error("header len %0d exceeds max body flits %0d", hdr_len_int, last_max_lp);
    end
  end

  assign link_ready_and_o = (state_q != FULL);
  assign packet_v_o       = (state_q == FULL);
  assign packet_o         = buf_q[pkt_w_lp-1:0];

endmodule
